counter_arbiter: RTL and testbench

Shares one 4-bit up-counter instance between up to NUM_REQ requesters. Each requester asks for a burst of N counting cycles. The arbiter grants one requester at a time and drives the counter's enable for exactly N cycles. It then returns the counter's final value and the number of wrap events seen during the burst. The block sits between the requester logic and the counter; it is the only driver of the counter's enable input.

---
 rtl/counter_arbiter.sv | 161 ++++++++++++++++
 tb/tb_counter_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_arbiter: shares one 4-bit up-counter between NUM_REQ requesters,   |
// | running len-cycle bursts. Optional macro COUNTER_ARBITER_RR_EN selects     |
// | round-robin arbitration, otherwise fixed priority with lowest index first. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8,
    parameter int WRAP_W  = LEN_W - 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [3:0]               result_count,
    output logic [WRAP_W-1:0]        result_wraps,
    output logic                     cnt_enable,
    input  logic [3:0]               cnt_count,
    input  logic                     cnt_overflow
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [WRAP_W-1:0]  wraps_q, wraps_d;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [LEN_W-1:0]   w_pick_len;
    logic [NUM_REQ-1:0] w_winner_oh;

`ifdef COUNTER_ARBITER_RR_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     w_cand;

    // Search starts at the pointer and wraps modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, ptr_q} + k[IDX_W:0];
            if (w_cand >= NUM_REQ[IDX_W:0]) begin
                w_cand = w_cand - NUM_REQ[IDX_W:0];
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_DONE) begin
            ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
        end
    end
`else
    // Scan from the top so the lowest requesting index is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_found = 1'b1;
                w_pick  = k[IDX_W-1:0];
            end
        end
    end
`endif

    assign w_pick_len = len[w_pick*LEN_W +: LEN_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            winner_q <= '0;
            rem_q    <= '0;
            wraps_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rem_q    <= rem_d;
            wraps_q  <= wraps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rem_d    = rem_q;
        wraps_d  = wraps_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    winner_d = w_pick;
                    wraps_d  = '0;
                    if (w_pick_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        rem_d   = w_pick_len;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end
                if (cnt_overflow && (wraps_q != '1)) begin
                    wraps_d = wraps_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Last enabled edge's overflow pulse lands in this cycle.
                state_d = S_DONE;
                if (cnt_overflow && (wraps_q != '1)) begin
                    wraps_d = wraps_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_winner_oh           = '0;
        w_winner_oh[winner_q] = 1'b1;
        grant        = (state_q != S_IDLE) ? w_winner_oh : '0;
        done         = (state_q == S_DONE) ? w_winner_oh : '0;
        cnt_enable   = (state_q == S_RUN);
        result_count = (state_q == S_DONE) ? cnt_count : 4'd0;
        result_wraps = (state_q == S_DONE) ? wraps_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_counter_arbiter: directed bench for counter_arbiter with a 4-bit        |
// | counter model attached. Honours COUNTER_ARBITER_RR_EN for contention.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_counter_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
    localparam int WRAP_W  = LEN_W - 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] len;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [3:0]               result_count;
    logic [WRAP_W-1:0]        result_wraps;
    logic                     cnt_enable;
    logic [3:0]               cnt_q;
    logic                     ovf_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .WRAP_W(WRAP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .len          (len),
        .grant        (grant),
        .done         (done),
        .result_count (result_count),
        .result_wraps (result_wraps),
        .cnt_enable   (cnt_enable),
        .cnt_count    (cnt_q),
        .cnt_overflow (ovf_q)
    );

    // Shared 4-bit up-counter with a registered overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= cnt_enable && (cnt_q == 4'hF);
            if (cnt_enable) cnt_q <= cnt_q + 4'd1;
        end
    end

    // Raises req[idx] in cycle t and records what happens up to the done pulse.
    task automatic run_burst(input int idx, input int lenv, input int drop_at,
                             output logic [3:0] g0, output int done_at,
                             output int en_n, output int en_first, output int en_last,
                             output int gbad, output logic [3:0] dmask,
                             output logic [3:0] rc, output logic [WRAP_W-1:0] rw);
        logic [3:0] exp_g;
        exp_g = 4'b0001 << idx;
        @(posedge clk); #1;
        req[idx] = 1'b1;
        len[idx*LEN_W +: LEN_W] = lenv[LEN_W-1:0];
        #1;
        g0 = grant;
        done_at = -1; en_n = 0; en_first = -1; en_last = -1; gbad = 0;
        dmask = '0; rc = '0; rw = '0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (c == drop_at) begin
                req[idx] = 1'b0;
                len[idx*LEN_W +: LEN_W] = 8'd1;
            end
            if (cnt_enable) begin
                en_n++;
                if (en_first < 0) en_first = c;
                en_last = c;
            end
            if (grant !== exp_g) gbad++;
            if (done !== 4'b0) begin
                done_at = c; dmask = done; rc = result_count; rw = result_wraps;
                req[idx] = 1'b0;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({grant, done, cnt_enable, result_count, result_wraps} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {grant, done, cnt_enable, result_count, result_wraps});
        end
    endtask

    task automatic test_single();
        logic [3:0] g0, dm, rc; logic [WRAP_W-1:0] rw;
        int da, en, ef, el, gb;
        run_burst(0, 5, 0, g0, da, en, ef, el, gb, dm, rc, rw);
        total++; if (g0 !== 4'b0)   begin bad++; $display("FAIL single_grant_t: got %b required 0000", g0); end
        total++; if (da !== 7)      begin bad++; $display("FAIL single_done_at: got %0d required 7", da); end
        total++; if (en !== 5)      begin bad++; $display("FAIL single_en_cycles: got %0d required 5", en); end
        total++; if (ef !== 1 || el !== 5) begin bad++; $display("FAIL single_en_window: got %0d..%0d required 1..5", ef, el); end
        total++; if (gb !== 0)      begin bad++; $display("FAIL single_grant: got %0d bad cycles required 0", gb); end
        total++; if (dm !== 4'b0001) begin bad++; $display("FAIL single_done_mask: got %b required 0001", dm); end
        total++; if (rc !== 4'd5)   begin bad++; $display("FAIL single_count: got %0d required 5", rc); end
        total++; if (rw !== '0)     begin bad++; $display("FAIL single_wraps: got %0d required 0", rw); end
    endtask

    task automatic test_wrap();
        logic [3:0] g0, dm, rc; logic [WRAP_W-1:0] rw;
        int da, en, ef, el, gb;
        run_burst(1, 20, 0, g0, da, en, ef, el, gb, dm, rc, rw);
        total++; if (da !== 22)     begin bad++; $display("FAIL wrap20_done_at: got %0d required 22", da); end
        total++; if (en !== 20)     begin bad++; $display("FAIL wrap20_en_cycles: got %0d required 20", en); end
        total++; if (dm !== 4'b0010) begin bad++; $display("FAIL wrap20_done_mask: got %b required 0010", dm); end
        total++; if (rc !== 4'd9)   begin bad++; $display("FAIL wrap20_count: got %0d required 9", rc); end
        total++; if (rw !== 5'd1)   begin bad++; $display("FAIL wrap20_wraps: got %0d required 1", rw); end
        run_burst(1, 32, 0, g0, da, en, ef, el, gb, dm, rc, rw);
        total++; if (da !== 34)     begin bad++; $display("FAIL wrap32_done_at: got %0d required 34", da); end
        total++; if (en !== 32)     begin bad++; $display("FAIL wrap32_en_cycles: got %0d required 32", en); end
        total++; if (rc !== 4'd9)   begin bad++; $display("FAIL wrap32_count: got %0d required 9", rc); end
        total++; if (rw !== 5'd2)   begin bad++; $display("FAIL wrap32_wraps: got %0d required 2", rw); end
    endtask

    task automatic test_zero_len();
        logic [3:0] g0, dm, rc; logic [WRAP_W-1:0] rw;
        int da, en, ef, el, gb;
        run_burst(2, 0, 0, g0, da, en, ef, el, gb, dm, rc, rw);
        total++; if (da !== 1)      begin bad++; $display("FAIL zero_done_at: got %0d required 1", da); end
        total++; if (en !== 0)      begin bad++; $display("FAIL zero_en_cycles: got %0d required 0", en); end
        total++; if (gb !== 0)      begin bad++; $display("FAIL zero_grant: got %0d bad cycles required 0", gb); end
        total++; if (dm !== 4'b0100) begin bad++; $display("FAIL zero_done_mask: got %b required 0100", dm); end
        total++; if (rc !== 4'd9)   begin bad++; $display("FAIL zero_count: got %0d required 9", rc); end
        total++; if (rw !== '0)     begin bad++; $display("FAIL zero_wraps: got %0d required 0", rw); end
    endtask

    task automatic test_drop_mid();
        logic [3:0] g0, dm, rc; logic [WRAP_W-1:0] rw;
        int da, en, ef, el, gb;
        run_burst(3, 10, 4, g0, da, en, ef, el, gb, dm, rc, rw);
        total++; if (en !== 10 || ef !== 1 || el !== 10) begin bad++; $display("FAIL drop_en: got %0d cycles %0d..%0d required 10 cycles 1..10", en, ef, el); end
        total++; if (da !== 12)     begin bad++; $display("FAIL drop_done_at: got %0d required 12", da); end
        total++; if (dm !== 4'b1000) begin bad++; $display("FAIL drop_done_mask: got %b required 1000", dm); end
        total++; if (gb !== 0)      begin bad++; $display("FAIL drop_grant: got %0d bad cycles required 0", gb); end
        total++; if (rc !== 4'd3)   begin bad++; $display("FAIL drop_count: got %0d required 3", rc); end
        total++; if (rw !== 5'd1)   begin bad++; $display("FAIL drop_wraps: got %0d required 1", rw); end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] g0, dm, rc; logic [WRAP_W-1:0] rw;
        int da, en, ef, el, gb;
        @(posedge clk); #1;
        req[0] = 1'b1;
        len[0 +: LEN_W] = 8'd8;
        repeat (3) @(posedge clk);
        #1;
        total++; if (cnt_enable !== 1'b1) begin bad++; $display("FAIL rstmid_running: got %b required 1", cnt_enable); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({grant, done, cnt_enable} !== 9'b0) begin bad++; $display("FAIL rstmid_outputs: got %b required 0", {grant, done, cnt_enable}); end
        req = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_burst(1, 4, 0, g0, da, en, ef, el, gb, dm, rc, rw);
        total++; if (da !== 6)      begin bad++; $display("FAIL rstmid_next_done_at: got %0d required 6", da); end
        total++; if (en !== 4)      begin bad++; $display("FAIL rstmid_next_en: got %0d required 4", en); end
        total++; if (dm !== 4'b0010) begin bad++; $display("FAIL rstmid_next_mask: got %b required 0010", dm); end
        total++; if (rc !== 4'd4)   begin bad++; $display("FAIL rstmid_next_count: got %0d required 4", rc); end
    endtask

    task automatic test_contention();
        int win [5];
        int dc  [5];
        int exp_win [5];
        int n;
        int nexp;
        int idx;
`ifdef COUNTER_ARBITER_RR_EN
        nexp = 5;
        exp_win = '{0, 1, 2, 3, 0};
`else
        nexp = 4;
        exp_win = '{0, 0, 0, 1, 0};
`endif
        @(posedge clk); #1;
        rst_n = 1'b0;
        req = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        len = {4{8'd3}};
        req = 4'b1111;
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done !== 4'b0) begin
                idx = -1;
                for (int i = 0; i < NUM_REQ; i++) if (done[i]) idx = (idx == -1) ? i : 99;
                win[n] = idx;
                dc[n]  = c;
                n++;
`ifndef COUNTER_ARBITER_RR_EN
                if (n == 3) req[0] = 1'b0;
`endif
                if (n == nexp) begin
                    req = '0;
                    break;
                end
            end
        end
        req = '0;
        total++; if (n !== nexp) begin bad++; $display("FAIL cont_bursts: got %0d required %0d", n, nexp); end
        total++; if (n > 0 && dc[0] !== 5) begin bad++; $display("FAIL cont_first_done: got %0d required 5", dc[0]); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (win[i] !== exp_win[i]) begin bad++; $display("FAIL cont_winner%0d: got %0d required %0d", i, win[i], exp_win[i]); end
            if (i > 0) begin
                total++;
                if (dc[i] - dc[i-1] !== 6) begin bad++; $display("FAIL cont_spacing%0d: got %0d required 6", i, dc[i] - dc[i-1]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_single();
        test_wrap();
        test_zero_len();
        test_drop_mid();
        test_reset_mid_run();
        test_contention();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
